// File: rtl/top_memoryaccess_pkg.sv
// Shared constants for the memory-access stage: decoded-op field positions,
// load/store width codes and FSM state encoding.
package top_memoryaccess_pkg;

  localparam int unsigned USE_LOAD_BIT  = 0;
  localparam int unsigned USE_STORE_BIT = 1;
  localparam int unsigned FUNCT3_BIT_L  = 2;
  localparam int unsigned FUNCT3_BIT_M  = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    StIdle,
    StAccess
  } state_e;

endpackage

// File: rtl/top_memoryaccess_mem_lane_align.sv
// Byte-lane steering for the data-memory port: store enables/replication,
// load extraction with sign/zero extension, and alignment/width legality.
module mem_lane_align
  import top_memoryaccess_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_ext_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] shifted;

  // Bring the addressed byte/halfword down to bit 0 before extending.
  assign shifted = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = rs2_i;
    load_ext_o = shifted;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_B: begin
        be_o       = 4'b0001 << addr_i;
        wdata_o    = {(XLEN/8){rs2_i[7:0]}};
        load_ext_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      F3_BU: begin
        be_o       = 4'b0001 << addr_i;
        wdata_o    = {(XLEN/8){rs2_i[7:0]}};
        load_ext_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      end
      F3_H: begin
        be_o       = 4'b0011 << addr_i;
        wdata_o    = {(XLEN/16){rs2_i[15:0]}};
        load_ext_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        misalign_o = addr_i[0];
      end
      F3_HU: begin
        be_o       = 4'b0011 << addr_i;
        wdata_o    = {(XLEN/16){rs2_i[15:0]}};
        load_ext_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
        misalign_o = addr_i[0];
      end
      F3_W: begin
        misalign_o = (addr_i != 2'b00);
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/top_memoryaccess.sv
// Memory-access stage: runs load/store handshakes on the data-memory port,
// stalls the phase while outstanding, and registers the bundle for writeback.
module top_memoryaccess
  import top_memoryaccess_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned OPLEN   = 9,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_memoryaccess,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic             jump_state_em,
  input  logic [4:0]       rdsel_em,
  input  logic [XLEN-1:0]  next_pc_em,
  input  logic [XLEN-1:0]  alu_out_em,
  input  logic [XLEN-1:0]  rs2data_em,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_ready,
  output logic             stall_memoryaccess,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic             jump_state_mw,
  output logic [4:0]       rdsel_mw,
  output logic [XLEN-1:0]  next_pc_mw,
  output logic [XLEN-1:0]  alu_out_mw,
  output logic [XLEN-1:0]  mem_rdata_mw,
  output logic             misalign_err_mw,
  output logic             bus_err_mw
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Transaction latched on entry to ACCESS.
  logic [OPLEN-1:0] op_q, op_d;
  logic             jump_q, jump_d;
  logic [4:0]       rdsel_q, rdsel_d;
  logic [XLEN-1:0]  npc_q, npc_d;
  logic [XLEN-1:0]  alu_q, alu_d;
  logic [XLEN-1:0]  rs2_q, rs2_d;

  // Writeback bundle.
  logic [OPLEN-1:0] op_mw_q, op_mw_d;
  logic             jump_mw_q, jump_mw_d;
  logic [4:0]       rdsel_mw_q, rdsel_mw_d;
  logic [XLEN-1:0]  npc_mw_q, npc_mw_d;
  logic [XLEN-1:0]  alu_mw_q, alu_mw_d;
  logic [XLEN-1:0]  rdata_mw_q, rdata_mw_d;
  logic             mis_mw_q, mis_mw_d;
  logic             bus_mw_q, bus_mw_d;

  logic             in_access;
  logic             em_is_mem;
  logic             cnt_at_limit;
  logic [OPLEN-1:0] sel_op;
  logic [XLEN-1:0]  sel_alu;
  logic [XLEN-1:0]  sel_rs2;
  logic [3:0]       lane_be;
  logic [XLEN-1:0]  lane_wdata;
  logic [XLEN-1:0]  lane_load_ext;
  logic             lane_misalign;

  assign in_access    = (state_q == StAccess);
  assign em_is_mem    = decoded_op_em[USE_LOAD_BIT] | decoded_op_em[USE_STORE_BIT];
  assign cnt_at_limit = (cnt_q == CntW'(TIMEOUT - 1));

  // The aligner checks the incoming op while idle and steers the latched one in ACCESS.
  assign sel_op  = in_access ? op_q  : decoded_op_em;
  assign sel_alu = in_access ? alu_q : alu_out_em;
  assign sel_rs2 = in_access ? rs2_q : rs2data_em;

  mem_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .funct3_i  (sel_op[FUNCT3_BIT_M:FUNCT3_BIT_L]),
    .addr_i    (sel_alu[1:0]),
    .rs2_i     (sel_rs2),
    .rdata_i   (dmem_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .load_ext_o(lane_load_ext),
    .misalign_o(lane_misalign)
  );

  assign dmem_req   = in_access;
  assign dmem_we    = in_access & op_q[USE_STORE_BIT];
  assign dmem_addr  = {alu_q[XLEN-1:2], 2'b00};
  assign dmem_be    = op_q[USE_STORE_BIT] ? lane_be : 4'b1111;
  assign dmem_wdata = lane_wdata;

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    op_d               = op_q;
    jump_d             = jump_q;
    rdsel_d            = rdsel_q;
    npc_d              = npc_q;
    alu_d              = alu_q;
    rs2_d              = rs2_q;
    op_mw_d            = op_mw_q;
    jump_mw_d          = jump_mw_q;
    rdsel_mw_d         = rdsel_mw_q;
    npc_mw_d           = npc_mw_q;
    alu_mw_d           = alu_mw_q;
    rdata_mw_d         = rdata_mw_q;
    mis_mw_d           = mis_mw_q;
    bus_mw_d           = bus_mw_q;
    stall_memoryaccess = 1'b0;
    case (state_q)
      StIdle: begin
        if (phase_memoryaccess) begin
          if (em_is_mem && !lane_misalign) begin
            stall_memoryaccess = 1'b1;
            op_d               = decoded_op_em;
            jump_d             = jump_state_em;
            rdsel_d            = rdsel_em;
            npc_d              = next_pc_em;
            alu_d              = alu_out_em;
            rs2_d              = rs2data_em;
            cnt_d              = '0;
            state_d            = StAccess;
          end else begin
            // Non-memory ops and rejected accesses retire in a single cycle.
            op_mw_d    = decoded_op_em;
            jump_mw_d  = jump_state_em;
            rdsel_mw_d = rdsel_em;
            npc_mw_d   = next_pc_em;
            alu_mw_d   = alu_out_em;
            rdata_mw_d = '0;
            mis_mw_d   = em_is_mem;
            bus_mw_d   = 1'b0;
          end
        end
      end
      StAccess: begin
        if (dmem_ready || cnt_at_limit) begin
          op_mw_d    = op_q;
          jump_mw_d  = jump_q;
          rdsel_mw_d = rdsel_q;
          npc_mw_d   = npc_q;
          alu_mw_d   = alu_q;
          mis_mw_d   = 1'b0;
          bus_mw_d   = ~dmem_ready;
          rdata_mw_d = (dmem_ready && op_q[USE_LOAD_BIT]) ? lane_load_ext : '0;
          state_d    = StIdle;
        end else begin
          cnt_d              = cnt_q + CntW'(1);
          stall_memoryaccess = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      jump_q     <= 1'b0;
      rdsel_q    <= '0;
      npc_q      <= '0;
      alu_q      <= '0;
      rs2_q      <= '0;
      op_mw_q    <= '0;
      jump_mw_q  <= 1'b0;
      rdsel_mw_q <= '0;
      npc_mw_q   <= '0;
      alu_mw_q   <= '0;
      rdata_mw_q <= '0;
      mis_mw_q   <= 1'b0;
      bus_mw_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      jump_q     <= jump_d;
      rdsel_q    <= rdsel_d;
      npc_q      <= npc_d;
      alu_q      <= alu_d;
      rs2_q      <= rs2_d;
      op_mw_q    <= op_mw_d;
      jump_mw_q  <= jump_mw_d;
      rdsel_mw_q <= rdsel_mw_d;
      npc_mw_q   <= npc_mw_d;
      alu_mw_q   <= alu_mw_d;
      rdata_mw_q <= rdata_mw_d;
      mis_mw_q   <= mis_mw_d;
      bus_mw_q   <= bus_mw_d;
    end
  end

  assign decoded_op_mw   = op_mw_q;
  assign jump_state_mw   = jump_mw_q;
  assign rdsel_mw        = rdsel_mw_q;
  assign next_pc_mw      = npc_mw_q;
  assign alu_out_mw      = alu_mw_q;
  assign mem_rdata_mw    = rdata_mw_q;
  assign misalign_err_mw = mis_mw_q;
  assign bus_err_mw      = bus_mw_q;

endmodule

// File: tb/tb_top_memoryaccess.sv
// Directed bench for top_memoryaccess: vector table of single transactions plus
// hand sequences for wait states, input stability, timeout and mid-access reset.
module tb_top_memoryaccess;

  logic        clk;
  logic        rst;
  logic        phase;
  logic [8:0]  op_em;
  logic        jump_em;
  logic [4:0]  rdsel_em;
  logic [31:0] npc_em;
  logic [31:0] alu_em;
  logic [31:0] rs2_em;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic [8:0]  op_mw;
  logic        jump_mw;
  logic [4:0]  rdsel_mw;
  logic [31:0] npc_mw;
  logic [31:0] alu_mw;
  logic [31:0] mrd_mw;
  logic        mis_mw;
  logic        bus_mw;

  int checks = 0;
  int errors = 0;

  top_memoryaccess #(
    .XLEN(32),
    .OPLEN(9),
    .TIMEOUT(16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .phase_memoryaccess(phase),
    .decoded_op_em     (op_em),
    .jump_state_em     (jump_em),
    .rdsel_em          (rdsel_em),
    .next_pc_em        (npc_em),
    .alu_out_em        (alu_em),
    .rs2data_em        (rs2_em),
    .dmem_req          (req),
    .dmem_we           (we),
    .dmem_addr         (addr),
    .dmem_be           (be),
    .dmem_wdata        (wdata),
    .dmem_rdata        (rdata),
    .dmem_ready        (ready),
    .stall_memoryaccess(stall),
    .decoded_op_mw     (op_mw),
    .jump_state_mw     (jump_mw),
    .rdsel_mw          (rdsel_mw),
    .next_pc_mw        (npc_mw),
    .alu_out_mw        (alu_mw),
    .mem_rdata_mw      (mrd_mw),
    .misalign_err_mw   (mis_mw),
    .bus_err_mw        (bus_mw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Op layout: bit0 load, bit1 store, bits 4:2 funct3.
  function automatic logic [8:0] mk_op(input logic ld, input logic st, input logic [2:0] f3);
    return {4'b0000, f3, st, ld};
  endfunction

  typedef struct {
    logic [8:0]  op;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    logic        exp_acc;
    logic        exp_mis;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[13];

  task automatic drive(input logic [8:0] op, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd);
    op_em    = op;
    alu_em   = alu;
    rs2_em   = rs2;
    rdsel_em = rd;
    jump_em  = rd[0];
    npc_em   = alu + 32'd4;
    phase    = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1; phase = 1'b0; op_em = '0; jump_em = 1'b0; rdsel_em = '0;
    npc_em = '0; alu_em = '0; rs2_em = '0; rdata = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_alu_mw", alu_mw, 32'd0);
    chk("rst_rdsel_mw", {27'd0, rdsel_mw}, 32'd0);
    chk("rst_errs", {30'd0, mis_mw, bus_mw}, 32'd0);
    rst = 1'b0;

    vecs[0]  = '{mk_op(1, 0, 3'b000), 32'h0000_1002, 32'h0, 32'h0080_0000, 32'hFFFF_FF80,
                 1, 0, 0, 4'hF, 32'h0};
    vecs[1]  = '{mk_op(0, 0, 3'b000), 32'hAAAA_AAAA, 32'h0, 32'h0, 32'h0, 0, 0, 0, 4'hF, 32'h0};
    vecs[2]  = '{mk_op(1, 0, 3'b100), 32'h0000_1002, 32'h0, 32'h0080_0000, 32'h0000_0080,
                 1, 0, 0, 4'hF, 32'h0};
    vecs[3]  = '{mk_op(1, 0, 3'b101), 32'h0000_1002, 32'h0, 32'hBEEF_0000, 32'h0000_BEEF,
                 1, 0, 0, 4'hF, 32'h0};
    vecs[4]  = '{mk_op(1, 0, 3'b001), 32'h0000_1002, 32'h0, 32'hBEEF_0000, 32'hFFFF_BEEF,
                 1, 0, 0, 4'hF, 32'h0};
    vecs[5]  = '{mk_op(1, 0, 3'b010), 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                 1, 0, 0, 4'hF, 32'h0};
    vecs[6]  = '{mk_op(1, 0, 3'b010), 32'h0000_1002, 32'h0, 32'h0, 32'h0, 0, 1, 0, 4'hF, 32'h0};
    vecs[7]  = '{mk_op(1, 0, 3'b001), 32'h0000_1001, 32'h0, 32'h0, 32'h0, 0, 1, 0, 4'hF, 32'h0};
    vecs[8]  = '{mk_op(0, 1, 3'b001), 32'h0000_2002, 32'h1234_5678, 32'h0, 32'h0,
                 1, 0, 1, 4'b1100, 32'h5678_5678};
    vecs[9]  = '{mk_op(0, 1, 3'b010), 32'h0000_2000, 32'hCAFE_BABE, 32'h0, 32'h0,
                 1, 0, 1, 4'b1111, 32'hCAFE_BABE};
    vecs[10] = '{mk_op(0, 1, 3'b000), 32'h0000_2001, 32'h0000_00A5, 32'h0, 32'h0,
                 1, 0, 1, 4'b0010, 32'hA5A5_A5A5};
    vecs[11] = '{mk_op(1, 0, 3'b011), 32'h0000_1000, 32'h0, 32'h0, 32'h0, 0, 1, 0, 4'hF, 32'h0};
    vecs[12] = '{mk_op(1, 0, 3'b000), 32'h0000_1003, 32'h0, 32'h7F00_0000, 32'h0000_007F,
                 1, 0, 0, 4'hF, 32'h0};

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].alu, vecs[i].rs2, 5'(i + 1));
      #1;
      chk($sformatf("v%0d_stall_idle", i), {31'd0, stall}, {31'd0, vecs[i].exp_acc});
      if (vecs[i].exp_acc) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_req", i), {31'd0, req}, 32'd1);
        chk($sformatf("v%0d_addr", i), addr, vecs[i].alu & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_be", i), {28'd0, be}, {28'd0, vecs[i].exp_be});
        chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, vecs[i].exp_we});
        if (vecs[i].exp_we) chk($sformatf("v%0d_wdata", i), wdata, vecs[i].exp_wd);
        ready = 1'b1;
        rdata = vecs[i].rdata;
        #1;
        chk($sformatf("v%0d_stall_ready", i), {31'd0, stall}, 32'd0);
      end
      @(posedge clk); #1;
      ready = 1'b0;
      phase = 1'b0;
      chk($sformatf("v%0d_req_after", i), {31'd0, req}, 32'd0);
      chk($sformatf("v%0d_rdata_mw", i), mrd_mw, vecs[i].exp_rd);
      chk($sformatf("v%0d_mis_mw", i), {31'd0, mis_mw}, {31'd0, vecs[i].exp_mis});
      chk($sformatf("v%0d_alu_mw", i), alu_mw, vecs[i].alu);
      chk($sformatf("v%0d_rdsel_mw", i), {27'd0, rdsel_mw}, 32'(i + 1));
      chk($sformatf("v%0d_npc_mw", i), npc_mw, vecs[i].alu + 32'd4);
    end

    // Phase low: bundle must hold.
    drive(mk_op(0, 0, 3'b000), 32'h5555_5555, 32'h0, 5'd31);
    phase = 1'b0;
    @(posedge clk); #1;
    chk("hold_alu_mw", alu_mw, 32'h0000_1003);
    chk("hold_rdsel_mw", {27'd0, rdsel_mw}, 32'd13);

    // SB with three wait cycles; inputs change mid-access and must be ignored.
    drive(mk_op(0, 1, 3'b000), 32'h0000_1003, 32'h1234_5678, 5'd7);
    #1;
    chk("sb_stall0", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("sb_req", {31'd0, req}, 32'd1);
    chk("sb_addr", addr, 32'h0000_1000);
    chk("sb_be", {28'd0, be}, 32'b1000);
    chk("sb_wdata", wdata, 32'h7878_7878);
    chk("sb_we", {31'd0, we}, 32'd1);
    chk("sb_stall1", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    alu_em = 32'hFFFF_FFFF;
    rs2_em = 32'h0;
    #1;
    chk("sb_stall2", {31'd0, stall}, 32'd1);
    chk("sb_addr_stable", addr, 32'h0000_1000);
    chk("sb_wdata_stable", wdata, 32'h7878_7878);
    @(posedge clk); #1;
    ready = 1'b1;
    #1;
    chk("sb_stall_ready", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    ready = 1'b0;
    phase = 1'b0;
    chk("sb_req_after", {31'd0, req}, 32'd0);
    chk("sb_alu_mw", alu_mw, 32'h0000_1003);

    // Timeout: ready held low.
    drive(mk_op(1, 0, 3'b010), 32'h0000_3000, 32'h0, 5'd9);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("to_stall_cycles", 32'(n), 32'd16);
    chk("to_req_last", {31'd0, req}, 32'd1);
    @(posedge clk); #1;
    phase = 1'b0;
    chk("to_bus_err", {31'd0, bus_mw}, 32'd1);
    chk("to_req_after", {31'd0, req}, 32'd0);
    chk("to_rdata_mw", mrd_mw, 32'd0);

    // Reset in the middle of an access.
    drive(mk_op(1, 0, 3'b010), 32'h0000_4008, 32'h0, 5'd5);
    @(posedge clk); #1;
    chk("rm_req_pre", {31'd0, req}, 32'd1);
    rst = 1'b1;
    phase = 1'b0;
    @(posedge clk); #1;
    chk("rm_req", {31'd0, req}, 32'd0);
    chk("rm_alu_mw", alu_mw, 32'd0);
    chk("rm_rdsel_mw", {27'd0, rdsel_mw}, 32'd0);
    chk("rm_errs", {30'd0, mis_mw, bus_mw}, 32'd0);
    rst = 1'b0;
    drive(mk_op(1, 0, 3'b010), 32'h0000_4008, 32'h0, 5'd5);
    @(posedge clk); #1;
    chk("rm_lw_req", {31'd0, req}, 32'd1);
    ready = 1'b1;
    rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    ready = 1'b0;
    phase = 1'b0;
    chk("rm_lw_rdata", mrd_mw, 32'h1357_9BDF);
    chk("rm_lw_alu", alu_mw, 32'h0000_4008);
    chk("rm_lw_req_after", {31'd0, req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/top_memoryaccess.md
Name: top_memoryaccess

Overview:
Memory-access stage of the multi-cycle RV32 core. It consumes the execute stage's `_em` bundle during `phase_memoryaccess` and runs load/store transactions on the data-memory request/ready port. It performs byte-lane steering and load sign/zero extension, and hands a registered `_mw` bundle to writeback. It holds the phase via `stall_memoryaccess` while a transaction is outstanding, with a bounded timeout.

Parameters:
- XLEN, 32, datapath width
- OPLEN, 9, decoded opcode width
- TIMEOUT, 16, max ACCESS-state cycles before abort (≥1)

Ports:
- clk  in  1  global clock
- rst  in  1  synchronous, active-high reset
- phase_memoryaccess  in  1  memory-access phase active (held by state machine while stall_memoryaccess=1)
- decoded_op_em  in  OPLEN  decoded op from execute
- jump_state_em  in  1  branch/compare result
- rdsel_em  in  5  destination register
- next_pc_em  in  XLEN  next PC
- alu_out_em  in  XLEN  ALU result / effective address
- rs2data_em  in  XLEN  store data
- dmem_req  out  1  request valid
- dmem_we  out  1  1=write
- dmem_addr  out  XLEN  word address, {alu_out[XLEN-1:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_rdata  in  XLEN  read word, valid when dmem_ready=1
- dmem_ready  in  1  accepts request / returns data
- stall_memoryaccess  out  1  to state machine: hold phase
- decoded_op_mw, jump_state_mw, rdsel_mw, next_pc_mw, alu_out_mw  out  (as _em)  registered pass-through
- mem_rdata_mw  out  XLEN  extended load data
- misalign_err_mw  out  1  misaligned/illegal-width access, no bus access issued
- bus_err_mw  out  1  transaction timed out

Behaviour:
- Reset (clk edge with rst=1): state IDLE, counter 0, all `_mw` outputs and error flags 0, dmem_req 0. Reset during ACCESS aborts; dmem_req deasserts the cycle after. No `_mw` update.
- op class: decoded_op[USE_LOAD_BIT], decoded_op[USE_STORE_BIT]. Width from decoded_op[FUNCT3_BIT_M:FUNCT3_BIT_L]: 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other value on a load/store is illegal.
- FSM IDLE:
  - phase_memoryaccess=0: no change; `_mw` outputs hold.
  - Phase=1 with a non-memory op: `_mw` captured at that edge, mem_rdata_mw=0, stall=0 (latency 1).
  - Phase=1 with a misaligned or illegal access (H with addr[0]=1, W with addr[1:0]≠0): no request, misalign_err_mw=1, `_mw` captured, stall=0.
  - Phase=1 with a legal load/store: stall=1 combinationally, inputs latched, go to ACCESS.
- FSM ACCESS:
  - dmem_req=1 from registered state.
  - addr/we/be/wdata come from latched values and stay stable until accepted.
  - stall = ~dmem_ready & (cnt≠TIMEOUT-1).
  - Handshake completes on dmem_req & dmem_ready. At that edge: `_mw` written, errors 0, and for loads mem_rdata_mw = extend(dmem_rdata >> 8*addr[1:0]). Return to IDLE.
  - Minimum load/store latency is 2 cycles in phase.
  - Timeout: cnt reaches TIMEOUT-1 without ready → bus_err_mw=1, mem_rdata_mw=0, return to IDLE, dmem_req drops next cycle.
- Byte enables:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<addr[1:0]
  - SW: 4'b1111
  - Loads: 4'b1111
- Store data: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passthrough.
- Error flags are cleared at every new capture.
- X on inputs propagates unmasked to outputs; no X-squashing.

Decomposition:
- Add to core_general.vh: USE_LOAD_BIT, USE_STORE_BIT, and the funct3 width codes (F3_B/H/W/BU/HU).
- Sub-module mem_lane_align (combinational): funct3, addr[1:0], rs2, rdata → be, wdata, load_ext, misalign.
- FSM, counter and pipeline registers stay in the top.

Test Plan:
- Non-memory op with alu_out_em=32'hAAAA_AAAA, rdsel_em=5'b10101 → one cycle later alu_out_mw=AAAA_AAAA, rdsel_mw=10101, stall never 1, dmem_req never 1.
- SB, alu_out=32'h0000_1003, rs2=32'h1234_5678, ready after 3 cycles → dmem_addr=0000_1000, be=4'b1000, wdata=7878_7878, we=1. Stall high 3 cycles, then drops in the ready cycle.
- LB at addr 0x...02 with rdata=32'h0080_0000 → mem_rdata_mw=FFFF_FF80. LBU same → 0000_0080. LHU at 0x...02 with rdata=32'hBEEF_0000 → 0000_BEEF.
- LW at alu_out=0x...0002 → no dmem_req, misalign_err_mw=1, stall=0.
- Load with dmem_ready tied 0, TIMEOUT=16 → stall high exactly 16 cycles, then bus_err_mw=1 and dmem_req low the following cycle.
- rst=1 mid-ACCESS → next cycle dmem_req=0, all `_mw`=0. A subsequent LW completes normally.
